// File: rtl/ysyx_25040101_ifu.sv
// ysyx_25040101_ifu: single-outstanding instruction fetch unit with request/response bus and retire handshake
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  input  logic        rsp_err_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic [31:0] next_pc_i,
  output logic        err_o,
  output logic [31:0] fetch_cnt_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] VALID = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;
  logic [2:0]  state, state_n;
  logic [31:0] pc, ibuf, cnt;
  logic        err, retire, misalign, rsp_ok;
  always_comb begin
    retire   = (state == VALID) && inst_ready_i;
    misalign = next_pc_i[1:0] != 2'b00;
    rsp_ok   = (state == WAIT) && rsp_valid_i && !rsp_err_i;
    state_n  = (state == IDLE)  ? REQ :
               (state == REQ)   ? (req_ready_i ? WAIT : REQ) :
               (state == WAIT)  ? (rsp_valid_i ? (rsp_err_i ? HALT : VALID) : WAIT) :
               (state == VALID) ? (inst_ready_i ? (misalign ? HALT : REQ) : VALID) :
               HALT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ibuf  <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (rsp_ok) ibuf <= rsp_data_i;
      if (retire && !misalign) pc <= next_pc_i;
      if (retire) cnt <= cnt + 32'd1;
      if (state_n == HALT) err <= 1'b1;
    end
  end
  assign req_valid_o  = state == REQ;
  assign req_addr_o   = pc;
  assign pc_o         = pc;
  assign inst_o       = ibuf;
  assign inst_valid_o = state == VALID;
  assign err_o        = err;
  assign fetch_cnt_o  = cnt;
endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// tb_ysyx_25040101_ifu: directed self-checking bench for the fetch unit
module tb_ysyx_25040101_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_o, req_ready_i = 1'b1;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        rsp_err_i = 1'b0;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o, inst_ready_i = 1'b0;
  logic [31:0] next_pc_i = '0;
  logic        err_o;
  logic [31:0] fetch_cnt_o;
  int n_cmp = 0;
  int n_bad = 0;
  ysyx_25040101_ifu dut (
    .clk(clk), .rst(rst),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .next_pc_i(next_pc_i), .err_o(err_o), .fetch_cnt_o(fetch_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got %b want 0", req_valid_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid got %b want 0", inst_valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %h want 0", fetch_cnt_o); end
    n_cmp++; if (pc_o !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_pc got %h want 80000000", pc_o); end
    n_cmp++; if (inst_o !== 32'd0) begin n_bad++; $display("FAIL rst_inst got %h want 0", inst_o); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL idle_req_valid got %b want 0", req_valid_o); end
    tick();
    n_cmp++; if (req_valid_o !== 1'b1) begin n_bad++; $display("FAIL first_req_valid got %b want 1", req_valid_o); end
    n_cmp++; if (req_addr_o !== 32'h8000_0000) begin n_bad++; $display("FAIL first_req_addr got %h want 80000000", req_addr_o); end
  endtask
  task automatic test_basic_fetch();
    req_ready_i = 1'b1;
    tick();
    n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL wait_req_valid got %b want 0", req_valid_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL wait_inst_valid got %b want 0", inst_valid_o); end
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h0000_0413;
    tick();
    rsp_valid_i = 1'b0;
    n_cmp++; if (inst_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_inst_valid got %b want 1", inst_valid_o); end
    n_cmp++; if (inst_o !== 32'h0000_0413) begin n_bad++; $display("FAIL basic_inst got %h want 00000413", inst_o); end
    n_cmp++; if (pc_o !== 32'h8000_0000) begin n_bad++; $display("FAIL basic_pc got %h want 80000000", pc_o); end
  endtask
  task automatic test_core_stall();
    inst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0413 || pc_o !== 32'h8000_0000)
        begin n_bad++; $display("FAIL stall_hold cyc %0d got v=%b inst=%h pc=%h want v=1 inst=00000413 pc=80000000", i, inst_valid_o, inst_o, pc_o); end
      n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_no_req cyc %0d got %b want 0", i, req_valid_o); end
    end
    inst_ready_i = 1'b1;
    next_pc_i    = 32'h8000_0004;
    tick();
    inst_ready_i = 1'b0;
    n_cmp++; if (req_valid_o !== 1'b1) begin n_bad++; $display("FAIL retire_req_valid got %b want 1", req_valid_o); end
    n_cmp++; if (req_addr_o !== 32'h8000_0004) begin n_bad++; $display("FAIL retire_req_addr got %h want 80000004", req_addr_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd1) begin n_bad++; $display("FAIL retire_cnt got %0d want 1", fetch_cnt_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL retire_inst_valid got %b want 0", inst_valid_o); end
  endtask
  task automatic test_backpressure();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_err_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0004)
        begin n_bad++; $display("FAIL bp_hold cyc %0d got v=%b addr=%h want v=1 addr=80000004", i, req_valid_o, req_addr_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL bp_rsp_ignored cyc %0d got err=%b want 0", i, err_o); end
    end
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    req_ready_i = 1'b1;
    tick();
    n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_to_wait got %b want 0", req_valid_o); end
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h0010_0093;
    tick();
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093)
      begin n_bad++; $display("FAIL bp_inst got v=%b inst=%h want v=1 inst=00100093", inst_valid_o, inst_o); end
    rsp_data_i = 32'hDEAD_BEEF;
    tick();
    rsp_valid_i = 1'b0;
    n_cmp++; if (inst_o !== 32'h0010_0093) begin n_bad++; $display("FAIL valid_rsp_ignored got %h want 00100093", inst_o); end
  endtask
  task automatic test_misaligned_retire();
    inst_ready_i = 1'b1;
    next_pc_i    = 32'h8000_0006;
    tick();
    inst_ready_i = 1'b0;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL mis_err got %b want 1", err_o); end
    n_cmp++; if (pc_o !== 32'h8000_0004) begin n_bad++; $display("FAIL mis_pc got %h want 80000004", pc_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || err_o !== 1'b1)
        begin n_bad++; $display("FAIL mis_halt cyc %0d got req=%b inst=%b err=%b want 0 0 1", i, req_valid_o, inst_valid_o, err_o); end
    end
  endtask
  task automatic test_bus_error();
    do_reset();
    req_ready_i = 1'b1;
    tick();
    tick();
    rsp_valid_i = 1'b1;
    rsp_err_i   = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL buserr_err got %b want 1", err_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || err_o !== 1'b1)
        begin n_bad++; $display("FAIL buserr_halt cyc %0d got req=%b inst=%b err=%b want 0 0 1", i, req_valid_o, inst_valid_o, err_o); end
    end
  endtask
  task automatic test_reset_in_wait();
    do_reset();
    req_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (req_valid_o !== 1'b0 || err_o !== 1'b0 || pc_o !== 32'h8000_0000)
      begin n_bad++; $display("FAIL wrst_async got req=%b err=%b pc=%h want 0 0 80000000", req_valid_o, err_o, pc_o); end
    tick();
    rst = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    rsp_valid_i = 1'b0;
    n_cmp++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0000)
      begin n_bad++; $display("FAIL wrst_restart got v=%b addr=%h want 1 80000000", req_valid_o, req_addr_o); end
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== 32'd0)
      begin n_bad++; $display("FAIL wrst_stale got v=%b inst=%h want 0 00000000", inst_valid_o, inst_o); end
    tick();
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h0000_0013;
    tick();
    rsp_valid_i = 1'b0;
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 32'h8000_0000)
      begin n_bad++; $display("FAIL wrst_fresh got v=%b inst=%h pc=%h want 1 00000013 80000000", inst_valid_o, inst_o, pc_o); end
  endtask
  task automatic test_back_to_back();
    inst_ready_i = 1'b1;
    next_pc_i    = 32'h8000_0100;
    tick();
    inst_ready_i = 1'b0;
    tick();
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h0050_0113;
    tick();
    rsp_valid_i = 1'b0;
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0113 || pc_o !== 32'h8000_0100)
      begin n_bad++; $display("FAIL b2b_inst got v=%b inst=%h pc=%h want 1 00500113 80000100", inst_valid_o, inst_o, pc_o); end
    inst_ready_i = 1'b1;
    next_pc_i    = 32'h8000_0104;
    tick();
    inst_ready_i = 1'b0;
    n_cmp++; if (fetch_cnt_o !== 32'd2 || req_addr_o !== 32'h8000_0104)
      begin n_bad++; $display("FAIL b2b_retire got cnt=%0d addr=%h want 2 80000104", fetch_cnt_o, req_addr_o); end
  endtask
  initial begin
    test_reset();
    test_basic_fetch();
    test_core_stall();
    test_backpressure();
    test_misaligned_retire();
    test_bus_error();
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
